// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encodings,
// default reset PC, sequential PC step and the address alignment helper.
package inst_fetch_unit_pkg;

  typedef enum logic [2:0] {
    IFU_FETCH    = 3'b001,
    IFU_WAIT_RSP = 3'b010,
    IFU_DELIVER  = 3'b100
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IFU_PC_STEP_DEFAULT  = 4;

  // Instruction fetches are word aligned, so the two low address bits are cleared.
  function automatic logic [31:0] ifu_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Bundles the fetch unit's I-cache request/response, redirect and decode
// handshakes. master = fetch unit side, slave = surrounding pipeline/cache.
interface inst_fetch_unit_if;

  logic        to_icache_req_valid;
  logic [31:0] to_icache_req_addr;
  logic        from_icache_req_ready;
  logic        from_icache_rsp_valid;
  logic [31:0] from_icache_rsp_data;
  logic        to_icache_rsp_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        to_id_valid;
  logic [31:0] to_id_inst;
  logic [31:0] to_id_pc;
  logic        from_id_ready;

  modport master (
    output to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
    output to_id_valid, to_id_inst, to_id_pc,
    input  from_icache_req_ready, from_icache_rsp_valid, from_icache_rsp_data,
    input  redirect_valid, redirect_pc, from_id_ready
  );

  modport slave (
    input  to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
    input  to_id_valid, to_id_inst, to_id_pc,
    output from_icache_req_ready, from_icache_rsp_valid, from_icache_rsp_data,
    output redirect_valid, redirect_pc, from_id_ready
  );

endinterface

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one outstanding I-cache request, redirect/flush handling and
// {pc, inst} delivery to decode. Define IFU_PERF_CNT_EN to add perf counters.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC_DEFAULT,
  parameter int          PC_STEP  = IFU_PC_STEP_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]         perf_fetch_cnt,
  output logic [31:0]         perf_wait_cnt,
  output logic [31:0]         perf_flush_cnt,
`endif
  inst_fetch_unit_if.master   bus
);

  ifu_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        discard_q, discard_d;

  logic        req_hs_s;
  logic        rsp_flush_s;
  logic [31:0] redir_pc_s;

  assign bus.to_icache_req_valid = (state_q == IFU_FETCH) && !rst;
  assign bus.to_icache_rsp_ready = (state_q == IFU_WAIT_RSP) && !rst;
  // A same-cycle redirect hides the held instruction so decode never takes a wrong-path op.
  assign bus.to_id_valid         = (state_q == IFU_DELIVER) && !bus.redirect_valid && !rst;
  assign bus.to_icache_req_addr  = pc_q;
  assign bus.to_id_pc            = pc_q;
  assign bus.to_id_inst          = ir_q;

  assign req_hs_s    = bus.to_icache_req_valid && bus.from_icache_req_ready;
  assign redir_pc_s  = ifu_align(bus.redirect_pc);
  assign rsp_flush_s = (state_q == IFU_WAIT_RSP) && bus.from_icache_rsp_valid &&
                       (discard_q || bus.redirect_valid);

  // Next-state, PC, instruction register and discard-flag computation.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    discard_d = discard_q;
    case (state_q)
      IFU_FETCH: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc_s;
          if (req_hs_s) begin
            // The old-address request was accepted anyway; its answer must be dropped.
            discard_d = 1'b1;
            state_d   = IFU_WAIT_RSP;
          end else begin
            state_d = IFU_FETCH;
          end
        end else if (req_hs_s) begin
          state_d = IFU_WAIT_RSP;
        end else begin
          state_d = IFU_FETCH;
        end
      end
      IFU_WAIT_RSP: begin
        if (bus.from_icache_rsp_valid) begin
          if (discard_q || bus.redirect_valid) begin
            discard_d = 1'b0;
            state_d   = IFU_FETCH;
            if (bus.redirect_valid) begin
              pc_d = redir_pc_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            ir_d    = bus.from_icache_rsp_data;
            state_d = IFU_DELIVER;
          end
        end else if (bus.redirect_valid) begin
          pc_d      = redir_pc_s;
          discard_d = 1'b1;
          state_d   = IFU_WAIT_RSP;
        end else begin
          state_d = IFU_WAIT_RSP;
        end
      end
      IFU_DELIVER: begin
        if (bus.redirect_valid) begin
          pc_d    = redir_pc_s;
          state_d = IFU_FETCH;
        end else if (bus.from_id_ready) begin
          pc_d    = pc_q + 32'(PC_STEP);
          state_d = IFU_FETCH;
        end else begin
          state_d = IFU_DELIVER;
        end
      end
      default: begin
        state_d   = IFU_FETCH;
        discard_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IFU_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= 32'h0000_0000;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      discard_q <= discard_d;
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_wait_q, perf_wait_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Event counters, free-running and wrapping at 2^32.
  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_wait_d  = perf_wait_q;
    perf_flush_d = perf_flush_q;
    if (bus.to_id_valid && bus.from_id_ready) begin
      perf_fetch_d = perf_fetch_q + 32'd1;
    end else begin
      perf_fetch_d = perf_fetch_q;
    end
    if (state_q == IFU_WAIT_RSP) begin
      perf_wait_d = perf_wait_q + 32'd1;
    end else begin
      perf_wait_d = perf_wait_q;
    end
    if (rsp_flush_s) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end else begin
      perf_flush_d = perf_flush_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'h0000_0000;
      perf_wait_q  <= 32'h0000_0000;
      perf_flush_q <= 32'h0000_0000;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_wait_q  <= perf_wait_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_wait_cnt  = perf_wait_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  logic unused_flush_s;
  assign unused_flush_s = rsp_flush_s;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: expected requests/deliveries are queued
// by the stimulus and popped by a negedge monitor; two DUTs cover both reset PCs.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        sel = 1'b0;
  logic        req_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'h0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        id_ready = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] exp_req_q[$];
  logic [63:0] exp_id_q[$];

  inst_fetch_unit_if bus();
  inst_fetch_unit_if bus2();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] pf1, pw1, pl1, pf2, pw2, pl2;
  inst_fetch_unit u_dut (.clk(clk), .rst(rst), .perf_fetch_cnt(pf1),
                         .perf_wait_cnt(pw1), .perf_flush_cnt(pl1), .bus(bus));
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (.clk(clk), .rst(rst2),
                         .perf_fetch_cnt(pf2), .perf_wait_cnt(pw2), .perf_flush_cnt(pl2), .bus(bus2));
`else
  inst_fetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus));
  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2));
`endif

  assign bus.from_icache_req_ready  = req_ready;
  assign bus.from_icache_rsp_valid  = rsp_valid;
  assign bus.from_icache_rsp_data   = rsp_data;
  assign bus.redirect_valid         = redir_valid;
  assign bus.redirect_pc            = redir_pc;
  assign bus.from_id_ready          = id_ready;
  assign bus2.from_icache_req_ready = req_ready;
  assign bus2.from_icache_rsp_valid = rsp_valid;
  assign bus2.from_icache_rsp_data  = rsp_data;
  assign bus2.redirect_valid        = redir_valid;
  assign bus2.redirect_pc           = redir_pc;
  assign bus2.from_id_ready         = id_ready;

  logic        o_req_valid, o_rsp_ready, o_id_valid;
  logic [31:0] o_req_addr, o_id_pc, o_id_inst;
  assign o_req_valid = sel ? bus2.to_icache_req_valid : bus.to_icache_req_valid;
  assign o_req_addr  = sel ? bus2.to_icache_req_addr  : bus.to_icache_req_addr;
  assign o_rsp_ready = sel ? bus2.to_icache_rsp_ready : bus.to_icache_rsp_ready;
  assign o_id_valid  = sel ? bus2.to_id_valid         : bus.to_id_valid;
  assign o_id_pc     = sel ? bus2.to_id_pc            : bus.to_id_pc;
  assign o_id_inst   = sel ? bus2.to_id_inst          : bus.to_id_inst;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboards on every request and delivery handshake.
  always @(negedge clk) begin
    if (o_req_valid && req_ready) begin
      if (exp_req_q.size() == 0) chk("req_unexpected", {32'h0, o_req_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("req_addr", {32'h0, o_req_addr}, {32'h0, exp_req_q.pop_front()});
    end
    if (o_id_valid && id_ready) begin
      if (exp_id_q.size() == 0) chk("id_unexpected", {o_id_pc, o_id_inst}, 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("id_pc_inst", {o_id_pc, o_id_inst}, exp_id_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req();
    int n = 0;
    while (!o_req_valid && n < 20) begin
      tick();
      n++;
    end
    if (!o_req_valid) chk("req_timeout", 64'h0, 64'h1);
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic do_rsp(input logic [31:0] data, input int lat);
    repeat (lat - 1) tick();
    rsp_valid = 1'b1;
    rsp_data  = data;
    tick();
    rsp_valid = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    exp_req_q.push_back(addr);
    exp_id_q.push_back({addr, data});
    do_req();
    do_rsp(data, lat);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    #1;
    chk("rst_req_valid", {63'h0, o_req_valid}, 64'h0);
    chk("rst_rsp_ready", {63'h0, o_rsp_ready}, 64'h0);
    chk("rst_id_valid",  {63'h0, o_id_valid},  64'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_id_valid", {63'h0, o_id_valid}, 64'h0);
    chk("post_rst_inst_pc",  {o_id_pc, o_id_inst}, 64'h0);
    chk("post_rst_req_valid", {63'h0, o_req_valid}, 64'h1);

    // 1: basic fetch, 3-cycle I-cache latency
    id_ready = 1'b1;
    fetch(32'h0000_0000, 32'h0000_0013, 3);
    #1 chk("t1_next_addr", {32'h0, o_req_addr}, 64'h4);

    // 2: decode stall for 5 cycles
    id_ready = 1'b0;
    exp_req_q.push_back(32'h0000_0004);
    do_req();
    do_rsp(32'h0010_0093, 2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_stall_valid", {63'h0, o_id_valid}, 64'h1);
      chk("t2_stall_pc_inst", {o_id_pc, o_id_inst}, {32'h4, 32'h0010_0093});
      tick();
    end
    exp_id_q.push_back({32'h4, 32'h0010_0093});
    id_ready = 1'b1;
    tick();
    #1 chk("t2_next_addr", {32'h0, o_req_addr}, 64'h8);

    // 3: redirect in WAIT_RSP, stale response arrives later
    exp_req_q.push_back(32'h0000_0008);
    do_req();
    tick();
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0100;
    tick();
    redir_valid = 1'b0;
    tick();
    rsp_valid = 1'b1;
    rsp_data  = 32'hDEAD_BEEF;
    tick();
    rsp_valid = 1'b0;
    #1 chk("t3_redirect_addr", {32'h0, o_req_addr}, 64'h100);
`ifdef IFU_PERF_CNT_EN
    chk("t3_perf_flush", {32'h0, pl1}, 64'h1);
`endif
    fetch(32'h0000_0100, 32'h0000_0113, 2);

    // 4: redirect to unaligned target coinciding with the response
    exp_req_q.push_back(32'h0000_0104);
    do_req();
    tick();
    rsp_valid   = 1'b1;
    rsp_data    = 32'h5555_AAAA;
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0203;
    tick();
    rsp_valid   = 1'b0;
    redir_valid = 1'b0;
    #1 chk("t4_redirect_addr", {32'h0, o_req_addr}, 64'h200);
    fetch(32'h0000_0200, 32'h2000_0093, 1);

    // 5: redirect in DELIVER while decode is ready
    exp_req_q.push_back(32'h0000_0204);
    do_req();
    do_rsp(32'hAAAA_5555, 1);
    redir_valid = 1'b1;
    redir_pc    = 32'h0000_0040;
    #1;
    chk("t5_masked_valid", {63'h0, o_id_valid}, 64'h0);
    chk("t5_ir_loaded", {32'h0, o_id_inst}, {32'h0, 32'hAAAA_5555});
    tick();
    redir_valid = 1'b0;
    #1 chk("t5_redirect_addr", {32'h0, o_req_addr}, 64'h40);
    fetch(32'h0000_0040, 32'h0000_0013, 2);

    // 6: PC wrap from FFFF_FFFC and reset while WAIT_RSP (second instance)
    rst = 1'b1;
    sel = 1'b1;
    tick();
    rst2 = 1'b0;
    #1 chk("t6_reset_pc", {32'h0, o_req_addr}, {32'h0, 32'hFFFF_FFFC});
    fetch(32'hFFFF_FFFC, 32'h0000_0073, 2);
    #1 chk("t6_wrap_addr", {32'h0, o_req_addr}, 64'h0);
    exp_req_q.push_back(32'h0000_0000);
    do_req();
    rst2 = 1'b1;
    #1;
    chk("t6_rst_rsp_ready", {63'h0, o_rsp_ready}, 64'h0);
    chk("t6_rst_req_valid", {63'h0, o_req_valid}, 64'h0);
    tick();
    rst2 = 1'b0;
    #1;
    chk("t6_after_rst_addr", {32'h0, o_req_addr}, {32'h0, 32'hFFFF_FFFC});
    chk("t6_after_rst_req_valid", {63'h0, o_req_valid}, 64'h1);
    chk("t6_after_rst_rsp_ready", {63'h0, o_rsp_ready}, 64'h0);
    fetch(32'hFFFF_FFFC, 32'h0000_0013, 1);

    tick();
    tick();
    chk("req_queue_drained", {32'h0, 32'(exp_req_q.size())}, 64'h0);
    chk("id_queue_drained",  {32'h0, 32'(exp_id_q.size())},  64'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- CPU front-end fetch stage that sits directly upstream of the instruction cache.
- Holds the PC and issues one 4-byte-aligned fetch request at a time over the I-cache valid/ready request channel.
- Accepts the 32-bit instruction on the I-cache response channel and presents {pc, inst} to decode through a valid/ready handshake.
- Applies redirects (branch/jump/exception) from the back end and discards wrong-path responses that are already in flight.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded by reset; low 2 bits must be 0
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
to_icache_req_valid  output  1  fetch request valid
to_icache_req_addr  output  32  fetch address = pc, bits[1:0]=0
from_icache_req_ready  input  1  I-cache accepts request
from_icache_rsp_valid  input  1  instruction response valid
from_icache_rsp_data  input  32  instruction word
to_icache_rsp_ready  output  1  fetch unit ready for response
redirect_valid  input  1  back-end redirect, single-cycle pulse
redirect_pc  input  32  redirect target; bits[1:0] forced to 0 internally
to_id_valid  output  1  instruction valid to decode
to_id_inst  output  32  instruction word
to_id_pc  output  32  PC of to_id_inst
from_id_ready  input  1  decode accepts instruction

Behaviour:
- Registers:
  - state: FETCH / WAIT_RSP / DELIVER, one-hot, 3 bits.
  - pc: 32 bits.
  - ir: 32 bits.
  - discard: 1 bit.
- Reset (rst=1 at a clock edge): state<=FETCH, pc<=RESET_PC, ir<=0, discard<=0.
- While rst=1, all valid/ready outputs are 0. After reset: to_id_valid=0, to_id_inst=0, to_id_pc=RESET_PC.
- Output decode:
  - to_icache_req_valid = (state==FETCH) && !rst.
  - to_icache_rsp_ready = (state==WAIT_RSP).
  - to_id_valid = (state==DELIVER) && !redirect_valid. A redirect masks delivery combinationally.
  - to_icache_req_addr = to_id_pc = pc; to_id_inst = ir.
- FETCH:
  - req handshake → WAIT_RSP.
  - redirect without handshake → pc<=redirect_pc, stay FETCH.
  - redirect with handshake → pc<=redirect_pc, discard<=1, go WAIT_RSP.
- WAIT_RSP:
  - rsp_valid && !discard && !redirect → ir<=rsp_data, go DELIVER.
  - rsp_valid && (discard || redirect) → response dropped, discard<=0, go FETCH. On redirect, pc<=redirect_pc.
  - redirect without rsp_valid → pc<=redirect_pc, discard<=1, stay WAIT_RSP.
- DELIVER:
  - redirect → pc<=redirect_pc, go FETCH. This holds even if from_id_ready=1, because to_id_valid is masked.
  - to_id_valid && from_id_ready → pc<=pc+PC_STEP (mod 2^32, wraps FFFF_FFFC→0000_0000), go FETCH.
  - Otherwise hold; pc and ir are stable while stalled.
- At most one outstanding I-cache request; a request is never withdrawn once to_icache_req_valid is asserted unless a redirect changes the address (the I-cache latches only on handshake).
- Minimum overhead per instruction is 3 cycles (FETCH, WAIT_RSP, DELIVER) plus I-cache latency.
- A reset mid-transaction abandons the outstanding request. The I-cache must be reset on the same rst.

Optional Feature:
- Macro: IFU_PERF_CNT_EN.
- When defined, adds 32-bit outputs:
  - perf_fetch_cnt: instructions delivered, counts to_id_valid&&from_id_ready.
  - perf_wait_cnt: cycles in WAIT_RSP.
  - perf_flush_cnt: responses dropped.
- Counters reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/header: state encodings IFU_FETCH=3'b001, IFU_WAIT_RSP=3'b010, IFU_DELIVER=3'b100; RESET_PC default; PC_STEP.
- No sub-module required. Optionally ifu_perf_counters, instantiated only under IFU_PERF_CNT_EN.

Test Plan:
1. Reset release, I-cache ready=1, rsp after 3 cycles with data 32'h0000_0013, id_ready=1 → req_addr=0x0, then to_id_pc=0x0/inst=0x13, next req_addr=0x4.
2. id_ready=0 for 5 cycles in DELIVER → to_id_valid stays 1, pc/inst stable. On id_ready=1 → next req_addr=pc+4.
3. Redirect to 0x100 while in WAIT_RSP; stale rsp 0xDEADBEEF arrives 2 cycles later → never on to_id. Next req_addr=0x100. perf_flush_cnt=1 if enabled.
4. Redirect to 0x203 coinciding with rsp_valid → response dropped, next req_addr=0x200.
5. Redirect to 0x40 in DELIVER with id_ready=1 the same cycle → to_id_valid=0 that cycle, next req_addr=0x40.
6. RESET_PC=32'hFFFF_FFFC, one delivered instruction → next req_addr=0x0000_0000 (wrap). Assert rst while in WAIT_RSP → state FETCH, req_addr=RESET_PC.
